// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit accumulator CPU: opcodes, FSM state
// encoding, ALU operation select and the memory-map boundaries.
package cpu_pkg;

    localparam logic [7:0] LDA_IMM = 8'h86;
    localparam logic [7:0] LDA_DIR = 8'h87;
    localparam logic [7:0] LDB_IMM = 8'h88;
    localparam logic [7:0] LDB_DIR = 8'h89;
    localparam logic [7:0] STA_DIR = 8'h96;
    localparam logic [7:0] STB_DIR = 8'h97;
    localparam logic [7:0] ADD_AB  = 8'h42;
    localparam logic [7:0] SUB_AB  = 8'h43;
    localparam logic [7:0] BRA     = 8'h20;
    localparam logic [7:0] BEQ     = 8'h23;

    localparam logic [7:0] ROM_END  = 8'd127;
    localparam logic [7:0] RW_BASE  = 8'd128;
    localparam logic [7:0] RW_END   = 8'd223;
    localparam logic [7:0] OUT_BASE = 8'd224;
    localparam logic [7:0] IN_BASE  = 8'd240;

    // Flag positions inside the {N,Z,V,C} condition-code register
    localparam int CCR_N = 3;
    localparam int CCR_Z = 2;
    localparam int CCR_V = 1;
    localparam int CCR_C = 0;

    typedef enum logic [4:0] {
        S_FETCH_0,
        S_FETCH_1,
        S_FETCH_2,
        S_DECODE,
        S_OPND_4,
        S_OPND_5,
        S_LDA_IMM_6,
        S_LDB_IMM_6,
        S_LDA_DIR_6,
        S_LDA_DIR_7,
        S_LDA_DIR_8,
        S_LDB_DIR_6,
        S_LDB_DIR_7,
        S_LDB_DIR_8,
        S_STA_6,
        S_STA_7,
        S_STB_6,
        S_STB_7,
        S_ADD_4,
        S_SUB_4,
        S_BRA_4,
        S_BRA_5,
        S_BRA_6,
        S_BEQ_4
    } state_t;

    typedef enum logic {
        ALU_ADD = 1'b0,
        ALU_SUB = 1'b1
    } alu_op_t;

    // Loads and stores all begin with the same two-cycle operand fetch
    function automatic logic has_operand(input logic [7:0] op);
        return (op == LDA_IMM) || (op == LDB_IMM) || (op == LDA_DIR) ||
               (op == LDB_DIR) || (op == STA_DIR) || (op == STB_DIR);
    endfunction

endpackage

// File: rtl/cpu_alu.sv
// Combinational 8-bit add/subtract unit producing the result and {N,Z,V,C}.
module cpu_alu
    import cpu_pkg::*;
(
    input  logic [7:0] i_a,
    input  logic [7:0] i_b,
    input  alu_op_t    i_op,
    output logic [7:0] o_result,
    output logic [3:0] o_nzvc
);

    logic [8:0] w_wide;
    logic       w_v;

    always_comb begin
        w_wide = 9'd0;
        w_v    = 1'b0;
        // The ninth bit is the carry for addition and the borrow for subtraction
        if (i_op == ALU_SUB) begin
            w_wide = {1'b0, i_a} - {1'b0, i_b};
            w_v    = (i_a[7] != i_b[7]) && (w_wide[7] != i_a[7]);
        end else begin
            w_wide = {1'b0, i_a} + {1'b0, i_b};
            w_v    = (i_a[7] == i_b[7]) && (w_wide[7] != i_a[7]);
        end
        o_result = w_wide[7:0];
        o_nzvc   = {w_wide[7], (w_wide[7:0] == 8'd0), w_v, w_wide[8]};
    end

endmodule

// File: rtl/cpu_8bit_core.sv
// 8-bit accumulator CPU: control FSM plus PC/MAR/IR/A/B/CCR datapath,
// mastering a bus whose memories all have one cycle of registered read latency.
module cpu_8bit_core
    import cpu_pkg::*;
#(
    parameter logic [7:0] RESET_PC = 8'h00
) (
    input  logic       clk,
    input  logic       reset,
    output logic [7:0] address,
    output logic       write,
    output logic [7:0] to_memory,
    input  logic [7:0] from_memory,
    output logic [7:0] pc_out,
    output logic [7:0] ir_out,
    output logic [7:0] a_out,
    output logic [7:0] b_out,
    output logic [3:0] ccr_out
);

    state_t     r_state;
    logic [7:0] r_pc;
    logic [7:0] r_mar;
    logic [7:0] r_ir;
    logic [7:0] r_a;
    logic [7:0] r_b;
    logic [3:0] r_ccr;

    alu_op_t    w_alu_op;
    logic [7:0] w_alu_result;
    logic [3:0] w_alu_nzvc;

    assign w_alu_op = (r_state == S_SUB_4) ? ALU_SUB : ALU_ADD;

    cpu_alu u_alu (
        .i_a      (r_a),
        .i_b      (r_b),
        .i_op     (w_alu_op),
        .o_result (w_alu_result),
        .o_nzvc   (w_alu_nzvc)
    );

    assign address   = r_mar;
    assign write     = (r_state == S_STA_7) || (r_state == S_STB_7);
    assign to_memory = ((r_state == S_STB_6) || (r_state == S_STB_7)) ? r_b : r_a;
    assign pc_out    = r_pc;
    assign ir_out    = r_ir;
    assign a_out     = r_a;
    assign b_out     = r_b;
    assign ccr_out   = r_ccr;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_FETCH_0;
            r_pc    <= RESET_PC;
            r_mar   <= 8'd0;
            r_ir    <= 8'd0;
            r_a     <= 8'd0;
            r_b     <= 8'd0;
            r_ccr   <= 4'd0;
        end else begin
            case (r_state)
                S_FETCH_0: begin
                    r_mar   <= r_pc;
                    r_state <= S_FETCH_1;
                end
                S_FETCH_1: begin
                    r_pc    <= r_pc + 8'd1;
                    r_state <= S_FETCH_2;
                end
                S_FETCH_2: begin
                    r_ir    <= from_memory;
                    r_state <= S_DECODE;
                end
                S_DECODE: begin
                    if (has_operand(r_ir)) begin
                        r_state <= S_OPND_4;
                    end else begin
                        case (r_ir)
                            ADD_AB:  r_state <= S_ADD_4;
                            SUB_AB:  r_state <= S_SUB_4;
                            BRA:     r_state <= S_BRA_4;
                            BEQ:     r_state <= r_ccr[CCR_Z] ? S_BRA_4 : S_BEQ_4;
                            default: r_state <= S_FETCH_0;
                        endcase
                    end
                end
                S_OPND_4: begin
                    r_mar   <= r_pc;
                    r_state <= S_OPND_5;
                end
                S_OPND_5: begin
                    r_pc <= r_pc + 8'd1;
                    case (r_ir)
                        LDA_IMM: r_state <= S_LDA_IMM_6;
                        LDB_IMM: r_state <= S_LDB_IMM_6;
                        LDA_DIR: r_state <= S_LDA_DIR_6;
                        LDB_DIR: r_state <= S_LDB_DIR_6;
                        STA_DIR: r_state <= S_STA_6;
                        STB_DIR: r_state <= S_STB_6;
                        default: r_state <= S_FETCH_0;
                    endcase
                end
                S_LDA_IMM_6: begin
                    r_a     <= from_memory;
                    r_state <= S_FETCH_0;
                end
                S_LDB_IMM_6: begin
                    r_b     <= from_memory;
                    r_state <= S_FETCH_0;
                end
                // Direct modes reuse MAR for the effective address, then wait out the read
                S_LDA_DIR_6: begin
                    r_mar   <= from_memory;
                    r_state <= S_LDA_DIR_7;
                end
                S_LDA_DIR_7: r_state <= S_LDA_DIR_8;
                S_LDA_DIR_8: begin
                    r_a     <= from_memory;
                    r_state <= S_FETCH_0;
                end
                S_LDB_DIR_6: begin
                    r_mar   <= from_memory;
                    r_state <= S_LDB_DIR_7;
                end
                S_LDB_DIR_7: r_state <= S_LDB_DIR_8;
                S_LDB_DIR_8: begin
                    r_b     <= from_memory;
                    r_state <= S_FETCH_0;
                end
                S_STA_6: begin
                    r_mar   <= from_memory;
                    r_state <= S_STA_7;
                end
                S_STA_7: r_state <= S_FETCH_0;
                S_STB_6: begin
                    r_mar   <= from_memory;
                    r_state <= S_STB_7;
                end
                S_STB_7: r_state <= S_FETCH_0;
                S_ADD_4, S_SUB_4: begin
                    r_a     <= w_alu_result;
                    r_ccr   <= w_alu_nzvc;
                    r_state <= S_FETCH_0;
                end
                S_BRA_4: begin
                    r_mar   <= r_pc;
                    r_state <= S_BRA_5;
                end
                S_BRA_5: r_state <= S_BRA_6;
                S_BRA_6: begin
                    r_pc    <= from_memory;
                    r_state <= S_FETCH_0;
                end
                S_BEQ_4: begin
                    r_pc    <= r_pc + 8'd1;
                    r_state <= S_FETCH_0;
                end
                default: r_state <= S_FETCH_0;
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_8bit_core.sv
// Scoreboard bench: an instruction-level reference model predicts architectural
// state at each instruction boundary and every bus write; monitors compare.
module tb_cpu_8bit_core;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] address, to_memory, pc_out, ir_out, a_out, b_out;
    logic [7:0] from_memory = 8'd0;
    logic       write;
    logic [3:0] ccr_out;

    cpu_8bit_core #(.RESET_PC(8'h00)) dut (
        .clk         (clk),
        .reset       (reset),
        .address     (address),
        .write       (write),
        .to_memory   (to_memory),
        .from_memory (from_memory),
        .pc_out      (pc_out),
        .ir_out      (ir_out),
        .a_out       (a_out),
        .b_out       (b_out),
        .ccr_out     (ccr_out)
    );

    always #5 clk = ~clk;

    typedef struct { int cyc; logic [7:0] pc, a, b, ir; logic [3:0] ccr; } st_exp_t;
    typedef struct { int cyc; logic [7:0] addr, data; } wr_exp_t;

    st_exp_t    q_st[$];
    wr_exp_t    q_wr[$];
    logic [7:0] img[256];
    logic [7:0] bus_mem[256];
    logic [7:0] mdl_mem[256];
    logic [7:0] ops[10];
    int         n_cmp = 0;
    int         n_err = 0;
    int         n_writes = 0;
    int         cyc = 0;
    logic [7:0] last_pc = 8'd0;

    // Input ports return a fixed pattern, output ports read back zero
    function automatic logic [7:0] bus_view(input logic [7:0] a, input logic [7:0] stored);
        if (a >= 8'hF0) return a ^ 8'hA5;
        if (a >= 8'hE0) return 8'h00;
        return stored;
    endfunction

    function automatic logic is_rw(input logic [7:0] a);
        return (a >= 8'h80) && (a <= 8'hDF);
    endfunction

    function automatic logic [7:0] rd_mdl(input logic [7:0] a);
        return bus_view(a, mdl_mem[a]);
    endfunction

    // Bus memory: image reloaded while reset is held, registered read otherwise
    always @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < 256; k++) bus_mem[k] <= img[k];
        end else if (write && is_rw(address)) begin
            bus_mem[address] <= to_memory;
        end
        from_memory <= bus_view(address, bus_mem[address]);
    end

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_run(input int n_instr);
        logic [7:0] pc, a, b, ir, ea, val;
        logic [3:0] ccr;
        int t, ua, ub, sa, sb, s, r, sv;
        for (int k = 0; k < 256; k++) mdl_mem[k] = img[k];
        pc = 8'h00; a = 8'h00; b = 8'h00; ccr = 4'h0; t = 0;
        for (int k = 0; k < n_instr; k++) begin
            ir = rd_mdl(pc);
            pc = pc + 8'd1;
            ua = int'(a); ub = int'(b);
            sa = (ua >= 128) ? ua - 256 : ua;
            sb = (ub >= 128) ? ub - 256 : ub;
            case (ir)
                8'h86, 8'h88: begin
                    val = rd_mdl(pc); pc = pc + 8'd1;
                    if (ir == 8'h86) a = val; else b = val;
                    t += 7;
                end
                8'h87, 8'h89: begin
                    ea = rd_mdl(pc); pc = pc + 8'd1;
                    val = rd_mdl(ea);
                    if (ir == 8'h87) a = val; else b = val;
                    t += 9;
                end
                8'h96, 8'h97: begin
                    ea = rd_mdl(pc); pc = pc + 8'd1;
                    val = (ir == 8'h96) ? a : b;
                    q_wr.push_back('{t + 7, ea, val});
                    if (is_rw(ea)) mdl_mem[ea] = val;
                    t += 8;
                end
                8'h42, 8'h43: begin
                    if (ir == 8'h42) begin
                        s = ua + ub; r = s % 256; sv = sa + sb;
                        ccr[0] = (s > 255);
                    end else begin
                        s = ua - ub; r = (s + 256) % 256; sv = sa - sb;
                        ccr[0] = (ua < ub);
                    end
                    ccr[1] = (sv > 127) || (sv < -128);
                    ccr[2] = (r == 0);
                    ccr[3] = (r >= 128);
                    a = 8'(r);
                    t += 5;
                end
                8'h20: begin pc = rd_mdl(pc); t += 7; end
                8'h23: begin
                    if (ccr[2]) begin pc = rd_mdl(pc); t += 7; end
                    else begin pc = pc + 8'd1; t += 5; end
                end
                default: t += 4;
            endcase
            q_st.push_back('{t, pc, a, b, ir, ccr});
        end
    endtask

    // Holds reset, queues predictions, releases and waits for them to drain
    task automatic run_program(input int n_instr);
        int budget;
        reset = 1'b1;
        q_st.delete();
        q_wr.delete();
        repeat (3) @(negedge clk);
        model_run(n_instr);
        budget = q_st[$].cyc + 20;
        n_writes = 0;
        reset = 1'b0;
        while (q_st.size() > 0 && budget > 0) begin
            @(posedge clk);
            budget--;
        end
        #2;
        chk("boundary_queue_drained", q_st.size(), 0);
        chk("write_queue_drained", q_wr.size(), 0);
    endtask

    task automatic clear_img();
        for (int k = 0; k < 256; k++) img[k] = 8'h00;
    endtask

    // Monitor: compares bus writes as they appear and state at predicted boundaries
    initial begin
        st_exp_t e;
        wr_exp_t w;
        forever begin
            @(posedge clk);
            if (reset) begin
                cyc = 0;
            end else begin
                cyc++;
                #1;
                if (write) begin
                    n_writes++;
                    if (q_wr.size() == 0) begin
                        n_cmp++;
                        n_err++;
                        $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, none expected (cycle %0d)",
                                 address, to_memory, cyc);
                    end else begin
                        w = q_wr.pop_front();
                        chk("write_cycle", cyc, w.cyc);
                        chk("write_addr", address, w.addr);
                        chk("write_data", to_memory, w.data);
                        $display("WRITE cyc=%0d addr=%02h data=%02h", cyc, address, to_memory);
                    end
                end
                if (q_st.size() > 0 && q_st[0].cyc == cyc) begin
                    e = q_st.pop_front();
                    chk("pc", pc_out, e.pc);
                    chk("a", a_out, e.a);
                    chk("b", b_out, e.b);
                    chk("ccr", ccr_out, e.ccr);
                    chk("ir", ir_out, e.ir);
                    last_pc = pc_out;
                    $display("INSTR cyc=%0d ir=%02h pc=%02h a=%02h b=%02h ccr=%04b",
                             cyc, ir_out, pc_out, a_out, b_out, ccr_out);
                end
            end
        end
    end

    initial begin
        int i, sel;
        logic [7:0] op;
        ops = '{8'h86, 8'h87, 8'h88, 8'h89, 8'h96, 8'h97, 8'h42, 8'h43, 8'h20, 8'h23};

        // Reset in the middle of a direct load (state 7 of the second instruction)
        clear_img();
        img[0] = 8'h86; img[1] = 8'h55; img[2] = 8'h87; img[3] = 8'h90; img[8'h90] = 8'h3C;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 14; k++) @(posedge clk);
        #2;
        chk("pre_reset_a", a_out, 8'h55);
        reset = 1'b1;
        #1;
        chk("rst_pc", pc_out, 8'h00);
        chk("rst_a", a_out, 8'h00);
        chk("rst_b", b_out, 8'h00);
        chk("rst_ir", ir_out, 8'h00);
        chk("rst_ccr", ccr_out, 4'h0);
        chk("rst_address", address, 8'h00);
        chk("rst_write", write, 1'b0);
        chk("rst_to_memory", to_memory, 8'h00);
        run_program(2);
        chk("restart_a", a_out, 8'h3C);

        // LDA #5, LDB #3, ADD
        clear_img();
        img[0] = 8'h86; img[1] = 8'h05; img[2] = 8'h88; img[3] = 8'h03; img[4] = 8'h42;
        run_program(3);
        chk("add_a", a_out, 8'h08);
        chk("add_b", b_out, 8'h03);
        chk("add_ccr", ccr_out, 4'b0000);

        // Signed overflow into bit 7
        img[1] = 8'h7F; img[3] = 8'h01;
        run_program(3);
        chk("ovf_a", a_out, 8'h80);
        chk("ovf_ccr", ccr_out, 4'b1010);

        // Store then direct load from RW space
        clear_img();
        img[0] = 8'h86; img[1] = 8'hAA; img[2] = 8'h96; img[3] = 8'h80; img[4] = 8'h87; img[5] = 8'h80;
        run_program(3);
        chk("sta_write_count", n_writes, 1);
        chk("lda_dir_a", a_out, 8'hAA);

        // SUB to zero then BEQ taken
        clear_img();
        img[0] = 8'h86; img[1] = 8'h02; img[2] = 8'h88; img[3] = 8'h02;
        img[4] = 8'h43; img[5] = 8'h23; img[6] = 8'h10;
        run_program(4);
        chk("beq_taken_pc", last_pc, 8'h10);
        chk("sub_zero_ccr", ccr_out, 4'b0100);

        // SUB with borrow then BEQ not taken
        img[3] = 8'h03;
        run_program(4);
        chk("beq_skip_pc", last_pc, 8'h07);
        chk("sub_borrow_a", a_out, 8'hFF);
        chk("sub_borrow_ccr", ccr_out, 4'b1001);

        // Unknown opcode
        clear_img();
        img[0] = 8'hFF;
        run_program(1);
        chk("nop_pc", last_pc, 8'h01);
        chk("nop_write_count", n_writes, 0);

        // Random programs filling the ROM, random RW contents
        for (int p = 0; p < 6; p++) begin
            for (int k = 0; k < 256; k++) img[k] = 8'($urandom);
            i = 0;
            while (i < 128) begin
                sel = $urandom_range(0, 11);
                op = (sel < 10) ? ops[sel] : 8'($urandom);
                img[i] = op;
                i++;
                if (i < 128) begin
                    case (op)
                        8'h87, 8'h89, 8'h96, 8'h97: begin
                            img[i] = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(128, 223));
                            i++;
                        end
                        8'h20, 8'h23: begin img[i] = 8'($urandom_range(0, 127)); i++; end
                        8'h86, 8'h88: begin img[i] = 8'($urandom); i++; end
                        default: ;
                    endcase
                end
            end
            run_program(50);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
